retire_map: RTL and testbench

RETIRE_MAP -- requirements
Module: retire_map

---
 rtl/retire_map_if.sv | 30 +++
 rtl/retire_map.sv | 70 +++++++
 tb/tb_retire_map.sv | 131 +++++++++++++
 3 files changed

// File: rtl/retire_map_if.sv
// retire_map_if -- commit/free/recovery bundle between the ROB side and the
// retirement map.
//   rob_commit        : per-slot {valid, dest_arf, dest_prf}, slot 0 oldest
//   branch_mispredict : mispredicted branch commits this cycle
//   freed_valid/prf   : per-slot old physical register released (registered)
//   recover_valid/map : committed architectural map snapshot for rename restore
interface retire_map_if #(
    parameter int N        = 4,
    parameter int ARF_REGS = 32,
    parameter int PRF_BITS = 6
);
    localparam int AW = $clog2(ARF_REGS);

    logic [N-1:0][AW+PRF_BITS:0]         rob_commit;
    logic                                branch_mispredict;
    logic [N-1:0]                        freed_valid;
    logic [N-1:0][PRF_BITS-1:0]          freed_prf;
    logic                                recover_valid;
    logic [ARF_REGS-1:0][PRF_BITS-1:0]   recover_map;

    modport master (
        output rob_commit, branch_mispredict,
        input  freed_valid, freed_prf, recover_valid, recover_map
    );

    modport slave (
        input  rob_commit, branch_mispredict,
        output freed_valid, freed_prf, recover_valid, recover_map
    );
endinterface

// File: rtl/retire_map.sv
// retire_map -- committed (architectural) register map.
// Applies up to N in-order commits per cycle to the architectural map, returns
// each slot's previous physical register one cycle later, and offers the map
// as a recovery snapshot the cycle after a branch mispredict commits.
// Ports:
//   clock : single clock, posedge
//   reset : synchronous, active low
//   bus   : retire_map_if.slave (commit packets in, freed/recover out)
module retire_map #(
    parameter int N        = 4,
    parameter int ARF_REGS = 32,
    parameter int PRF_BITS = 6
) (
    input  logic        clock,
    input  logic        reset,
    retire_map_if.slave bus
);
    localparam int AW = $clog2(ARF_REGS);

    logic [ARF_REGS-1:0][PRF_BITS-1:0] r_map;
    logic [N-1:0]                      r_freed_valid;
    logic [N-1:0][PRF_BITS-1:0]        r_freed_prf;
    logic                              r_recover_valid;

    logic [ARF_REGS-1:0][PRF_BITS-1:0] w_map;
    logic [N-1:0]                      w_free;
    logic [N-1:0][PRF_BITS-1:0]        w_old;
    logic [N-1:0][AW-1:0]              w_arf;

    // Walk the slots oldest first over a working copy of the map: each slot
    // reads the mapping left by any older same-cycle write to its register,
    // and the youngest writer to a register ends up stored.
    always_comb begin
        w_map  = r_map;
        w_free = '0;
        w_old  = '0;
        w_arf  = '0;
        for (int i = 0; i < N; i++) begin
            w_arf[i] = bus.rob_commit[i][PRF_BITS +: AW];
            if (bus.rob_commit[i][AW+PRF_BITS] && (w_arf[i] != '0)) begin
                w_free[i]       = 1'b1;
                w_old[i]        = w_map[w_arf[i]];
                w_map[w_arf[i]] = bus.rob_commit[i][PRF_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < ARF_REGS; r++) begin
                r_map[r] <= PRF_BITS'(r);
            end
            r_freed_valid   <= '0;
            r_freed_prf     <= '0;
            r_recover_valid <= 1'b0;
        end else begin
            r_map           <= w_map;
            r_freed_valid   <= w_free;
            r_freed_prf     <= w_old;
            r_recover_valid <= bus.branch_mispredict;
        end
    end

    // The snapshot already includes the mispredict cycle's commits because
    // r_map is updated on the same edge that raises recover_valid.
    assign bus.freed_valid   = r_freed_valid;
    assign bus.freed_prf     = r_freed_prf;
    assign bus.recover_valid = r_recover_valid;
    assign bus.recover_map   = r_map;
endmodule

// File: tb/tb_retire_map.sv
module tb_retire_map;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    retire_map_if #(.N(N), .ARF_REGS(32), .PRF_BITS(6)) bus ();

    retire_map #(.N(N), .ARF_REGS(32), .PRF_BITS(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic            rst_n;
        logic            mp;
        logic [3:0]      v;
        logic [3:0][4:0] arf;
        logic [3:0][5:0] prf;
        logic [3:0]      efv;
        logic [3:0][5:0] efp;
        logic            erv;
        int              midx;
        logic [5:0]      mval;
    } vec_t;

    vec_t vecs[14];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic rst_n, input logic mp, input logic [3:0] v,
                         input logic [3:0][4:0] arf, input logic [3:0][5:0] prf);
        @(negedge clock);
        reset = rst_n;
        bus.branch_mispredict = mp;
        for (int i = 0; i < N; i++) bus.rob_commit[i] = {v[i], arf[i], prf[i]};
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.branch_mispredict = 1'b0;
        bus.rob_commit = '0;

        // rst, mp, valid, arf{s3..s0}, prf{s3..s0}, exp freed_valid, exp freed_prf, exp rv, map idx, map val
        vecs[0]  = '{0, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {6'd0, 6'd0, 6'd0, 6'd60},
                     4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 0, 9, 6'd9};
        vecs[1]  = '{1, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd0},
                     4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 0, 0, 6'd0};
        vecs[2]  = '{1, 0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd0, 6'd40},
                     4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, 0, 5, 6'd40};
        vecs[3]  = '{1, 0, 4'b0011, {5'd0, 5'd0, 5'd7, 5'd7}, {6'd0, 6'd0, 6'd34, 6'd33},
                     4'b0011, {6'd0, 6'd0, 6'd33, 6'd7}, 0, 7, 6'd34};
        vecs[4]  = '{1, 0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd12},
                     4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 0, 0, 6'd0};
        vecs[5]  = '{1, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {6'd0, 6'd0, 6'd0, 6'd50},
                     4'b0001, {6'd0, 6'd0, 6'd0, 6'd3}, 1, 3, 6'd50};
        vecs[6]  = '{1, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd0},
                     4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 0, 5, 6'd40};
        // slot0 targets r0, slot2 invalid, slots 1 and 3 chain on r5
        vecs[7]  = '{1, 0, 4'b1011, {5'd5, 5'd6, 5'd5, 5'd0}, {6'd42, 6'd1, 6'd41, 6'd12},
                     4'b1010, {6'd41, 6'd0, 6'd40, 6'd0}, 0, 5, 6'd42};
        vecs[8]  = '{1, 1, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd0},
                     4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 1, 6, 6'd6};
        vecs[9]  = '{1, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {6'd0, 6'd0, 6'd0, 6'd51},
                     4'b0001, {6'd0, 6'd0, 6'd0, 6'd50}, 1, 3, 6'd51};
        vecs[10] = '{1, 0, 4'b1100, {5'd9, 5'd8, 5'd0, 5'd0}, {6'd21, 6'd20, 6'd0, 6'd0},
                     4'b1100, {6'd9, 6'd8, 6'd0, 6'd0}, 0, 9, 6'd21};
        vecs[11] = '{1, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd4}, {6'd0, 6'd0, 6'd0, 6'd30},
                     4'b0001, {6'd0, 6'd0, 6'd0, 6'd4}, 1, 4, 6'd30};
        // reset while outputs are pending, with a commit and mispredict present
        vecs[12] = '{0, 1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {6'd0, 6'd0, 6'd0, 6'd60},
                     4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 0, 9, 6'd9};
        vecs[13] = '{1, 0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0}, {6'd0, 6'd0, 6'd0, 6'd0},
                     4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 0, 4, 6'd4};

        // Reset state: identity map across all architectural registers.
        drive(1'b0, 1'b0, 4'b0000, '0, '0);
        chk("reset freed_valid", int'(bus.freed_valid), 0);
        chk("reset recover_valid", int'(bus.recover_valid), 0);
        for (int r = 0; r < 32; r++) chk($sformatf("reset map[%0d]", r), int'(bus.recover_map[r]), r);

        for (int k = 0; k < 14; k++) begin
            drive(vecs[k].rst_n, vecs[k].mp, vecs[k].v, vecs[k].arf, vecs[k].prf);
            chk($sformatf("v%0d freed_valid", k), int'(bus.freed_valid), int'(vecs[k].efv));
            for (int i = 0; i < N; i++)
                if (vecs[k].efv[i])
                    chk($sformatf("v%0d freed_prf[%0d]", k, i), int'(bus.freed_prf[i]), int'(vecs[k].efp[i]));
            chk($sformatf("v%0d recover_valid", k), int'(bus.recover_valid), int'(vecs[k].erv));
            chk($sformatf("v%0d map[%0d]", k, vecs[k].midx), int'(bus.recover_map[vecs[k].midx]),
                int'(vecs[k].mval));
        end

        // Back-to-back mispredicts: one pulse per mispredict cycle, then drop.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 4'b0000, '0, '0);
            chk($sformatf("b2b pulse %0d", c), int'(bus.recover_valid), 1);
        end
        drive(1'b1, 1'b0, 4'b0000, '0, '0);
        chk("b2b drop", int'(bus.recover_valid), 0);

        // Sustained full-width commits to one register over consecutive cycles:
        // each slot frees the previous writer's register.
        drive(1'b1, 1'b0, 4'b1111, {5'd10, 5'd10, 5'd10, 5'd10}, {6'd44, 6'd43, 6'd42, 6'd41});
        chk("burst0 freed_valid", int'(bus.freed_valid), 15);
        chk("burst0 freed_prf[0]", int'(bus.freed_prf[0]), 10);
        chk("burst0 freed_prf[3]", int'(bus.freed_prf[3]), 43);
        drive(1'b1, 1'b0, 4'b1111, {5'd11, 5'd10, 5'd11, 5'd10}, {6'd48, 6'd47, 6'd46, 6'd45});
        chk("burst1 freed_prf[0]", int'(bus.freed_prf[0]), 44);
        chk("burst1 freed_prf[1]", int'(bus.freed_prf[1]), 11);
        chk("burst1 freed_prf[2]", int'(bus.freed_prf[2]), 45);
        chk("burst1 freed_prf[3]", int'(bus.freed_prf[3]), 46);
        chk("burst1 map[10]", int'(bus.recover_map[10]), 47);
        chk("burst1 map[11]", int'(bus.recover_map[11]), 48);

        drive(1'b1, 1'b0, 4'b0000, '0, '0);
        chk("idle freed_valid", int'(bus.freed_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
